// File: rtl/regfile_scb_pkg.sv
// regfile_scb: shared defaults, pending-counter type and register reset value.
// Optional same-cycle writeback bypass: define REGFILE_SCB_WB_BYPASS_EN.
package regfile_scb_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 4;
  localparam int NUM_REGS_DEF = 15;
  localparam int PEND_W_DEF   = 2;
  localparam int NUM_RD_DEF   = 2;

  typedef logic [PEND_W_DEF-1:0] pend_t;

  function automatic logic [63:0] reg_rst_val(
    input int unsigned idx
  );
    return 64'(idx);
  endfunction
endpackage

// File: rtl/regfile_scb_if.sv
// regfile_scb: read, writeback and reservation bus.
// master drives addresses/requests, slave is the register file.
interface regfile_scb_if
  import regfile_scb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]             rd_busy;
  logic                          wb_en;
  logic [ADDR_W-1:0]             wb_addr;
  logic [DATA_W-1:0]             wb_data;
  logic                          set_en;
  logic [ADDR_W-1:0]             set_addr;
  logic                          set_ready;

  modport master (
    output rd_addr, wb_en, wb_addr, wb_data,
    output set_en, set_addr,
    input  rd_data, rd_busy, set_ready
  );

  modport slave (
    input  rd_addr, wb_en, wb_addr, wb_data,
    input  set_en, set_addr,
    output rd_data, rd_busy, set_ready
  );
endinterface

// File: rtl/regfile_scb_pend_ctr.sv
// regfile_scb: per-register pending-write counter.
// inc and dec together leave the count unchanged.
module regfile_pend_ctr #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              saturated
);
  assign saturated = &count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && !saturated) begin
      count <= count + PEND_W'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - PEND_W'(1);
    end
  end
endmodule

// File: rtl/regfile_scb.sv
// regfile_scb: register file with per-register pending-write scoreboard.
// Define REGFILE_SCB_WB_BYPASS_EN to forward same-cycle writeback to reads.
module regfile_scb
  import regfile_scb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int PEND_W   = PEND_W_DEF
) (
  input logic          clk,
  input logic          rst_n,
  regfile_scb_if.slave bus
);
  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [PEND_W-1:0] pend [NUM_REGS];
  logic [NUM_REGS-1:0] sat;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic wb_ok;
  logic set_sat;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0] rd_busy;

  assign wb_ok = bus.wb_en && ({1'b0, bus.wb_addr} < NREGS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= DATA_W'(reg_rst_val(i));
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wb_ok && bus.wb_addr == ADDR_W'(i))
          regs[i] <= bus.wb_data;
    end
  end

  // Out-of-range set_addr reads as ready; the set itself matches no counter.
  always_comb begin
    set_sat = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (bus.set_addr == ADDR_W'(i))
        set_sat = sat[i];
  end

  assign bus.set_ready = ~set_sat;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctr
    assign inc[g] = bus.set_en && !set_sat &&
                    bus.set_addr == ADDR_W'(g);
    assign dec[g] = wb_ok && bus.wb_addr == ADDR_W'(g);

    regfile_pend_ctr #(
      .PEND_W(PEND_W)
    ) u_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (inc[g]),
      .dec      (dec[g]),
      .count    (pend[g]),
      .saturated(sat[g])
    );
  end

`ifdef REGFILE_SCB_WB_BYPASS_EN
  logic fwd_busy;

  // Busy as it will be after this edge's decrement.
  always_comb begin
    fwd_busy = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (dec[i])
        fwd_busy = inc[i] ? (pend[i] != '0)
                          : (pend[i] > PEND_W'(1));
  end
`endif

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k] = '0;
      rd_busy[k] = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus.rd_addr[k] == ADDR_W'(i)) begin
          rd_data[k] = regs[i];
          rd_busy[k] = pend[i] != '0;
        end
      end
`ifdef REGFILE_SCB_WB_BYPASS_EN
      if (wb_ok && rst_n &&
          bus.wb_addr == bus.rd_addr[k]) begin
        rd_data[k] = bus.wb_data;
        rd_busy[k] = fwd_busy;
      end
`endif
    end
  end

  assign bus.rd_data = rd_data;
  assign bus.rd_busy = rd_busy;
endmodule

// File: tb/tb_regfile_scb.sv
// regfile_scb bench: directed vectors, expectations queued and checked
// by an independent monitor on the falling edge.
module tb_regfile_scb;
  import regfile_scb_pkg::*;

`ifdef REGFILE_SCB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d1;
    logic        b1;
    logic        rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  regfile_scb_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2)) bus ();

  regfile_scb #(
    .DATA_W(32), .NUM_REGS(15), .ADDR_W(4),
    .NUM_RD(2), .PEND_W(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (bus.rd_data[0] !== e.d0 || bus.rd_busy[0] !== e.b0 ||
          bus.rd_data[1] !== e.d1 || bus.rd_busy[1] !== e.b1 ||
          bus.set_ready !== e.rdy) begin
        miscompares++;
        $display("FAIL %s: got d0=%h b0=%b d1=%h b1=%b rdy=%b want d0=%h b0=%b d1=%h b1=%b rdy=%b",
                 e.name, bus.rd_data[0], bus.rd_busy[0],
                 bus.rd_data[1], bus.rd_busy[1], bus.set_ready,
                 e.d0, e.b0, e.d1, e.b1, e.rdy);
      end
    end
  end

  task automatic drive(input logic [3:0] a0, input logic [3:0] a1,
                       input logic we, input logic [3:0] wa,
                       input logic [31:0] wd,
                       input logic se, input logic [3:0] sa);
    bus.rd_addr[0] = a0;
    bus.rd_addr[1] = a1;
    bus.wb_en      = we;
    bus.wb_addr    = wa;
    bus.wb_data    = wd;
    bus.set_en     = se;
    bus.set_addr   = sa;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] d0, input logic b0,
                     input logic [31:0] d1, input logic b1,
                     input logic rdy);
    exp_t e;
    e.name = name; e.d0 = d0; e.b0 = b0;
    e.d1 = d1; e.b1 = b1; e.rdy = rdy;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      drive(4'(i), 4'(14 - i), 0, 0, 0, 0, 0);
      chk("reset_read", 32'(i), 0, 32'(14 - i), 0, 1);
    end
    drive(15, 0, 0, 0, 0, 0, 0);
    chk("reset_oob", 0, 0, 0, 0, 1);
    rst_n = 1'b1;

    drive(3, 15, 1, 3, 32'hDEADBEEF, 0, 0);
    chk("wr3_same", BYP ? 32'hDEADBEEF : 32'd3, 0, 0, 0, 1);
    drive(3, 15, 1, 15, 32'h12345678, 0, 0);
    chk("wr3_after", 32'hDEADBEEF, 0, 0, 0, 1);
    drive(14, 4, 0, 0, 0, 0, 0);
    chk("wr15_ignored", 32'd14, 0, 32'd4, 0, 1);
    drive(3, 15, 0, 0, 0, 0, 0);
    chk("rd15_zero", 32'hDEADBEEF, 0, 0, 0, 1);

    drive(5, 6, 0, 0, 0, 1, 5);
    chk("set5_a", 32'd5, 0, 32'd6, 0, 1);
    chk("set5_b", 32'd5, 1, 32'd6, 0, 1);
    drive(5, 6, 1, 5, 32'hA5, 0, 5);
    chk("wb5_a", BYP ? 32'hA5 : 32'd5, 1, 32'd6, 0, 1);
    drive(5, 6, 1, 5, 32'h5A, 0, 5);
    chk("wb5_b", BYP ? 32'h5A : 32'hA5, BYP ? 1'b0 : 1'b1,
        32'd6, 0, 1);
    drive(5, 6, 0, 0, 0, 0, 5);
    chk("idle5", 32'h5A, 0, 32'd6, 0, 1);
    drive(5, 6, 1, 5, 32'h77, 0, 5);
    chk("wb5_underflow", BYP ? 32'h77 : 32'h5A, 0, 32'd6, 0, 1);
    drive(5, 6, 0, 0, 0, 1, 5);
    chk("set5_after_uf", 32'h77, 0, 32'd6, 0, 1);
    drive(5, 6, 0, 0, 0, 0, 5);
    chk("busy5_one", 32'h77, 1, 32'd6, 0, 1);
    drive(5, 6, 1, 5, 32'h77, 0, 5);
    chk("wb5_clear", 32'h77, BYP ? 1'b0 : 1'b1, 32'd6, 0, 1);

    drive(2, 5, 0, 0, 0, 1, 2);
    chk("sat_set1", 32'd2, 0, 32'h77, 0, 1);
    chk("sat_set2", 32'd2, 1, 32'h77, 0, 1);
    chk("sat_set3", 32'd2, 1, 32'h77, 0, 1);
    chk("sat_set4_drop", 32'd2, 1, 32'h77, 0, 0);
    drive(2, 5, 1, 2, 32'h22, 0, 2);
    chk("sat_wb", BYP ? 32'h22 : 32'd2, 1, 32'h77, 0, 0);
    drive(2, 5, 0, 0, 0, 0, 2);
    chk("sat_ready_back", 32'h22, 1, 32'h77, 0, 1);
    drive(2, 5, 1, 2, 32'h23, 1, 2);
    chk("set_wb_same", BYP ? 32'h23 : 32'h22, 1, 32'h77, 0, 1);
    drive(2, 5, 0, 0, 0, 1, 2);
    chk("set_to_three", 32'h23, 1, 32'h77, 0, 1);
    drive(2, 5, 0, 0, 0, 0, 2);
    chk("count_was_two", 32'h23, 1, 32'h77, 0, 0);

    drive(9, 2, 1, 2, 32'h24, 1, 9);
    chk("set9_wb2", 32'd9, 0, BYP ? 32'h24 : 32'h23, 1, 1);
    drive(9, 2, 0, 0, 0, 0, 2);
    chk("set9_wb2_after", 32'd9, 1, 32'h24, 1, 1);

    drive(7, 7, 1, 7, 32'h55, 0, 0);
    chk("bypass7", BYP ? 32'h55 : 32'd7, 0,
        BYP ? 32'h55 : 32'd7, 0, 1);
    drive(7, 7, 0, 0, 0, 0, 0);
    chk("bypass7_after", 32'h55, 0, 32'h55, 0, 1);

    rst_n = 1'b0;
    drive(9, 3, 0, 0, 0, 0, 2);
    chk("async_rst", 32'd9, 0, 32'd3, 0, 1);
    rst_n = 1'b1;
    drive(9, 3, 0, 0, 0, 1, 9);
    chk("post_rst_set", 32'd9, 0, 32'd3, 0, 1);
    drive(9, 3, 0, 0, 0, 0, 9);
    chk("post_rst_busy", 32'd9, 1, 32'd3, 0, 1);

    for (int n = 0; n < 10 && q.size() > 0; n++)
      @(posedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
